// File: rtl/serdes_pkg.sv
// Shared symbol constants and lock-FSM state type for the serial receive path.
package serdes_pkg;

  localparam int SYMBOL_W   = 10;
  localparam int ALIGN_GOOD = 3;
  localparam int SYNC_MISS  = 4;

  localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYMBOL_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SYNC  = 2'd2
  } align_state_t;

  function automatic logic is_k28_5(input logic [SYMBOL_W-1:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational K28.5 detector (either running disparity) on the shift register.
module comma_detect
  import serdes_pkg::*;
(
  input  logic [SYMBOL_W-1:0] sr,
  output logic                hit
);

  assign hit = is_k28_5(sr);

endmodule

// File: rtl/comma_aligner.sv
// Serial-to-10b comma aligner with HUNT/ALIGN/SYNC lock FSM.
// Optional macro COMMA_REALIGN_EN: off-phase comma in SYNC realigns at once.
//
// state   | meaning
// HUNT    | no word phase; any comma sets the phase
// ALIGN   | phase set, counting consecutive on-phase commas
// SYNC    | locked; off-phase commas counted as misses
module comma_aligner
  import serdes_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sdata,
  output logic [SYMBOL_W-1:0] datout,
  output logic                dvalid,
  output logic                comma,
  output logic                sync
);

  localparam logic [3:0] LAST_BIT  = 4'(SYMBOL_W - 1);
  localparam logic [1:0] GOOD_LOCK = 2'(ALIGN_GOOD);
  localparam logic [2:0] MISS_LOST = 3'(SYNC_MISS);

  logic [SYMBOL_W-1:0] sr_q, sr_d;
  logic [SYMBOL_W-1:0] datout_q, datout_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  align_state_t        state_q, state_d;
  logic [1:0]          good_cnt_q, good_cnt_d;
  logic [2:0]          miss_cnt_q, miss_cnt_d;
  logic                dvalid_q, dvalid_d;
  logic                comma_q, comma_d;
  logic                sync_q, sync_d;
  logic                hit, last_bit, align_ev, boundary;

  comma_detect u_comma_detect (
    .sr  (sr_q),
    .hit (hit)
  );

  always_comb begin
    sr_d       = {sr_q[SYMBOL_W-2:0], sdata};
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    align_ev   = 1'b0;
    last_bit   = (bit_cnt_q == LAST_BIT);

    unique case (state_q)
      ST_HUNT: begin
        if (hit) align_ev = 1'b1;
      end
      ST_ALIGN: begin
        if (hit) begin
          if (last_bit) begin
            good_cnt_d = good_cnt_q + 2'd1;
            if (good_cnt_d == GOOD_LOCK) begin
              state_d    = ST_SYNC;
              miss_cnt_d = '0;
            end
          end else begin
            align_ev = 1'b1;
          end
        end
      end
      ST_SYNC: begin
        if (hit) begin
          if (last_bit) begin
            miss_cnt_d = '0;
          end else begin
`ifdef COMMA_REALIGN_EN
            align_ev = 1'b1;
`else
            miss_cnt_d = miss_cnt_q + 3'd1;
            if (miss_cnt_d == MISS_LOST) state_d = ST_HUNT;
`endif
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // A realignment restarts the symbol phase and emits the comma itself.
    if (align_ev) begin
      state_d    = ST_ALIGN;
      good_cnt_d = 2'd1;
    end

    boundary  = align_ev || (last_bit && (state_q != ST_HUNT));
    bit_cnt_d = (align_ev || last_bit) ? 4'd0 : bit_cnt_q + 4'd1;

    datout_d = boundary ? sr_q : datout_q;
    comma_d  = boundary ? hit  : comma_q;
    dvalid_d = boundary;
    sync_d   = (state_d == ST_SYNC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      state_q    <= ST_HUNT;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      datout_q   <= '0;
      dvalid_q   <= 1'b0;
      comma_q    <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      datout_q   <= datout_d;
      dvalid_q   <= dvalid_d;
      comma_q    <= comma_d;
      sync_q     <= sync_d;
    end
  end

  assign datout = datout_q;
  assign dvalid = dvalid_q;
  assign comma  = comma_q;
  assign sync   = sync_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: per-cycle reference model plus directed literal checks.
module tb_comma_aligner;

  localparam logic [9:0] RDN = 10'b0011111010;
  localparam logic [9:0] RDP = 10'b1100000101;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       sdata   = 1'b0;
  logic [9:0] datout;
  logic       dvalid, comma, sync;

  int n_tests = 0;
  int n_fail  = 0;
  int n_dv    = 0;
  int rst_events = 0;

  logic [9:0] dsym [9] = '{10'b1010101010, 10'b0101010101, 10'b1101001011,
                           10'b0110110100, 10'b1001011001, 10'b0100110110,
                           10'b1011010010, 10'b0010110101, 10'b1100101101};

  comma_aligner dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sdata   (sdata),
    .datout  (datout),
    .dvalid  (dvalid),
    .comma   (comma),
    .sync    (sync)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: lock level, cycles since the phase was set, good/miss tallies.
  logic [9:0] m_win;
  int         m_lock, m_since, m_good, m_miss, seen_events;
  logic [9:0] e_datout;
  logic       e_dvalid, e_comma, e_sync, samp_bit;

  task automatic model_step();
    logic is_comma, emit, realign;
    m_win    = {m_win[8:0], samp_bit};
    is_comma = (m_win == RDN) || (m_win == RDP);
    m_since++;
    emit     = 1'b0;
    realign  = 1'b0;
    e_dvalid = 1'b0;
    if (m_lock != 0 && (m_since % 10) == 0) begin
      emit = 1'b1;
      if (is_comma && m_lock == 1) begin
        m_good++;
        if (m_good == 3) begin
          m_lock = 2;
          m_miss = 0;
        end
      end else if (is_comma) begin
        m_miss = 0;
      end
    end else if (is_comma) begin
      if (m_lock == 2) begin
`ifdef COMMA_REALIGN_EN
        realign = 1'b1;
`else
        m_miss++;
        if (m_miss == 4) m_lock = 0;
`endif
      end else begin
        realign = 1'b1;
      end
    end
    if (realign) begin
      m_lock  = 1;
      m_good  = 1;
      m_since = 0;
      emit    = 1'b1;
    end
    if (emit) begin
      e_dvalid = 1'b1;
      e_datout = m_win;
      e_comma  = is_comma;
    end
    e_sync = (m_lock == 2);
  endtask

  initial forever begin
    @(posedge clk);
    samp_bit = sdata;
  end

  initial forever begin
    @(negedge reset_n);
    rst_events++;
  end

  initial begin
    logic fresh;
    seen_events = -1;
    forever begin
      @(negedge clk);
      fresh = !reset_n || (seen_events != rst_events);
      if (fresh) begin
        m_win = '0; m_lock = 0; m_since = 0; m_good = 0; m_miss = 0;
        e_datout = '0; e_dvalid = 1'b0; e_comma = 1'b0; e_sync = 1'b0;
        if (reset_n) seen_events = rst_events;
      end
      chk1("model_dvalid", dvalid, e_dvalid);
      chk1("model_sync", sync, e_sync);
      if (e_dvalid || fresh) begin
        chk10("model_datout", datout, e_datout);
        chk1("model_comma", comma, e_comma);
      end
      if (dvalid && reset_n) n_dv++;
      if (!fresh) model_step();
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    sdata = b;
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) drive_bit(s[i]);
  endtask

  task automatic send_bits(input logic [9:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(s[i]);
  endtask

  // Comma then data symbol d; dvalid must appear one clock after the comma's last bit.
  task automatic comma_then(input logic [9:0] c, input logic [9:0] d,
                            input string tag, input logic sync_after);
    send_sym(c);
    drive_bit(d[9]);
    chk1({tag, "_dv_early"}, dvalid, 1'b0);
    drive_bit(d[8]);
    chk1({tag, "_dv"}, dvalid, 1'b1);
    chk1({tag, "_comma"}, comma, 1'b1);
    chk10({tag, "_datout"}, datout, c);
    chk1({tag, "_sync"}, sync, sync_after);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
  endtask

  // Comma shifted 3 bits late inside a 20-bit slot, keeping the outer phase.
  task automatic off_comma(input logic [9:0] c);
    send_bits(10'b0000000010, 3);
    send_sym(c);
    send_bits(10'b0001010101, 7);
  endtask

  initial begin
    int dv_snap;
    repeat (3) @(negedge clk);
    chk10("rst_datout", datout, 10'd0);
    chk1("rst_dvalid", dvalid, 1'b0);
    chk1("rst_comma", comma, 1'b0);
    chk1("rst_sync", sync, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    send_bits(10'b0000110100, 7);
    comma_then(RDN, dsym[0], "hunt", 1'b0);
    for (int i = 1; i < 9; i++) send_sym(dsym[i]);
    chki("align_pulses", n_dv, 9);
    chk1("align_sync", sync, 1'b0);

    comma_then(RDN, dsym[0], "good2", 1'b0);
    for (int i = 1; i < 9; i++) send_sym(dsym[i]);
    comma_then(RDN, dsym[0], "lock", 1'b1);
    for (int i = 1; i < 4; i++) send_sym(dsym[i]);

`ifndef COMMA_REALIGN_EN
    off_comma(RDN);
    comma_then(RDN, dsym[2], "sync_hold", 1'b1);
    off_comma(RDP);
    off_comma(RDN);
    off_comma(RDP);
    send_sym(dsym[3]);
    chk1("miss3_sync", sync, 1'b1);
`endif

    comma_then(RDN, dsym[4], "resync", 1'b1);
    off_comma(RDN);
`ifdef COMMA_REALIGN_EN
    chk1("realign_sync", sync, 1'b0);
`else
    chk1("miss1_sync", sync, 1'b1);
`endif
    off_comma(RDP);
    off_comma(RDN);
    off_comma(RDP);
    dv_snap = n_dv;
    for (int i = 0; i < 3; i++) send_sym(dsym[i]);
`ifndef COMMA_REALIGN_EN
    chk1("lost_sync", sync, 1'b0);
    chki("hunt_no_dv", n_dv - dv_snap, 0);
`endif

    send_sym(dsym[5]);
    comma_then(RDP, dsym[0], "rl1", 1'b0);
    for (int i = 1; i < 9; i++) send_sym(dsym[i]);
    comma_then(RDP, dsym[0], "rl2", 1'b0);
    for (int i = 1; i < 9; i++) send_sym(dsym[i]);
    comma_then(RDP, dsym[0], "rl3", 1'b1);

    send_bits(dsym[6] >> 5, 5);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk10("midrst_datout", datout, 10'd0);
    chk1("midrst_dvalid", dvalid, 1'b0);
    chk1("midrst_comma", comma, 1'b0);
    chk1("midrst_sync", sync, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    send_bits(dsym[6], 5);

    comma_then(RDP, RDP, "p0", 1'b0);
    comma_then(RDP, RDP, "p1", 1'b1);
    for (int k = 0; k < 3; k++) comma_then(RDP, RDP, "pk", 1'b1);
    send_sym(dsym[0]);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
